adc_sample_sched: RTL

Sequencer for the ADC capture path, clocked on clk_3m. It decides when the ADC controller converts, either single-shot from the debounced button or periodically in continuous mode. It runs bursts of 2^AVG_LOG2 conversions, averages them into one 12-bit result that feeds the ROM/display path, and flags timeouts and overruns.

---
 rtl/adc_sample_sched_if.sv | 9 +
 rtl/adc_sample_sched.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/adc_sample_sched_if.sv
// ADC controller handshake: conversion request out, completion strobe and result back.
interface adc_sample_sched_if;
   logic        get_adc_data;
   logic        adc_data_ready;
   logic [11:0] adc_data;

   modport master (output get_adc_data, input adc_data_ready, input adc_data);
   modport slave  (input get_adc_data, output adc_data_ready, output adc_data);
endinterface

// File: rtl/adc_sample_sched.sv
// ADC capture sequencer: button/periodic triggers, bursts of 2^AVG_LOG2 conversions
// averaged into one 12-bit sample, with timeout and trigger-overrun flags.
module adc_sample_sched #(
   parameter int unsigned PERIOD_CYC  = 3200,
   parameter int unsigned AVG_LOG2    = 2,
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter int unsigned GAP_CYC     = 4
) (
   input  logic               clk_3m,
   input  logic               reset_n,
   input  logic               mode,
   input  logic               button_lvl,
   input  logic               err_clr,
   adc_sample_sched_if.master adc,
   output logic [11:0]        sample_out,
   output logic               sample_valid,
   output logic               busy,
   output logic               timeout_err,
   output logic               overrun
);
   localparam int unsigned ACC_W = 12 + AVG_LOG2;
   localparam int unsigned CNT_W = AVG_LOG2 + 1;
   localparam int unsigned PER_W = $clog2(PERIOD_CYC);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

   localparam logic [CNT_W-1:0] N_SAMP   = CNT_W'(1 << AVG_LOG2);
   localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   typedef enum logic [1:0] {IDLE, CONV, GAP, OUT} state_t;

   state_t             state, state_nx;
   logic               btn_s1, btn_s2, btn_prev;
   logic [PER_W-1:0]   ptmr;
   logic               tick;
   logic               rdy_prev;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic [TO_W-1:0]    tcnt;
   logic [GAP_W-1:0]   gcnt;
   logic               pending;

   logic               btn_edge, trigger, rdy_evt;
   logic               start, take, expire;
   logic [ACC_W-1:0]   acc_sum;
   logic [CNT_W-1:0]   cnt_inc;

   assign btn_edge = btn_s2 & ~btn_prev;
   assign trigger  = btn_edge | tick;
   assign rdy_evt  = adc.adc_data_ready & ~rdy_prev;
   assign acc_sum  = acc + ACC_W'(adc.adc_data);
   assign cnt_inc  = cnt + CNT_W'(1);

   assign adc.get_adc_data = (state == CONV);
   assign busy             = (state != IDLE);
   assign sample_valid     = (state == OUT);

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      take     = 1'b0;
      expire   = 1'b0;
      unique case (state)
         IDLE: if (trigger || pending) begin
            start    = 1'b1;
            state_nx = CONV;
         end
         CONV: if (rdy_evt) begin
            take     = 1'b1;
            state_nx = (cnt_inc == N_SAMP) ? OUT : GAP;
         end else if (tcnt == TO_LAST) begin
            expire   = 1'b1;
            state_nx = IDLE;
         end
         GAP:  if (gcnt == GAP_LAST) state_nx = CONV;
         OUT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_3m or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge clk_3m or negedge reset_n) begin
      if (!reset_n) begin
         btn_s1   <= 1'b0;
         btn_s2   <= 1'b0;
         btn_prev <= 1'b0;
         rdy_prev <= 1'b0;
         ptmr     <= '0;
         tick     <= 1'b0;
      end else begin
         btn_s1   <= button_lvl;
         btn_s2   <= btn_s1;
         btn_prev <= btn_s2;
         rdy_prev <= adc.adc_data_ready;
         if (!mode) begin
            ptmr <= PER_LOAD;
            tick <= 1'b0;
         end else if (ptmr == '0) begin
            ptmr <= PER_LOAD;
            tick <= 1'b1;
         end else begin
            ptmr <= ptmr - PER_W'(1);
            tick <= 1'b0;
         end
      end
   end

   // sample_out is loaded from the final sum on entry to OUT so it lines up with sample_valid
   always_ff @(posedge clk_3m or negedge reset_n) begin
      if (!reset_n) begin
         acc        <= '0;
         cnt        <= '0;
         tcnt       <= '0;
         gcnt       <= '0;
         sample_out <= '0;
      end else begin
         if (start || expire) begin
            acc <= '0;
            cnt <= '0;
         end else if (take) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
         end
         if (take && (cnt_inc == N_SAMP))
            sample_out <= 12'(acc_sum >> AVG_LOG2);
         tcnt <= (state == CONV && !rdy_evt) ? tcnt + TO_W'(1) : '0;
         gcnt <= (state == GAP) ? gcnt + GAP_W'(1) : '0;
      end
   end

   // A trigger arriving while a pending request is being started stays queued.
   always_ff @(posedge clk_3m or negedge reset_n) begin
      if (!reset_n) begin
         pending     <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE) pending <= pending & trigger;
         else if (trigger)  pending <= 1'b1;
         overrun     <= err_clr ? 1'b0 : (overrun | (busy & trigger & pending));
         timeout_err <= err_clr ? 1'b0 : (timeout_err | expire);
      end
   end
endmodule
